// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared field offsets, BCD limits, time struct and BCD helpers
//            for the time-of-day counter.
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

   // Bit offsets of each two-digit field inside the packed time bus
   localparam int HH_LSB = 24;
   localparam int MM_LSB = 16;
   localparam int SS_LSB = 8;
   localparam int CC_LSB = 0;

   // Largest legal value of each field, in BCD
   localparam logic [7:0] BCD_MAX_MS  = 8'h59;
   localparam logic [7:0] BCD_MAX_CC  = 8'h99;
   localparam logic [7:0] BCD_MAX_H24 = 8'h23;
   localparam logic [7:0] BCD_MAX_H12 = 8'h12;

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
      logic [7:0] cc;
   } clock_time_t;

   // Both digits are decimal and the value does not exceed lim. Valid BCD
   // orders the same way as binary, so a plain compare is enough.
   function automatic logic bcd_valid(input logic [7:0] b, input logic [7:0] lim);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= lim);
   endfunction

   // Two-digit BCD increment without wrap handling (caller handles the limit)
   function automatic logic [7:0] bcd_inc(input logic [7:0] b);
      if (b[3:0] == 4'd9)
         return {b[7:4] + 4'd1, 4'd0};
      else
         return {b[7:4], b[3:0] + 4'd1};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter
// Purpose  : Two-digit BCD counter running MIN..MAX with load and wrap carry.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MIN = 8'h00,
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       carry
);

   logic [7:0] r_val;

   // Carry is combinational so the whole chain ripples within one advance
   assign carry = inc && (r_val == MAX);
   assign value = r_val;

   // Load has priority over increment; increment wraps MAX back to MIN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_val <= MIN;
      else if (load)
         r_val <= load_val;
      else if (inc)
         r_val <= (r_val == MAX) ? MIN : bcd_inc(r_val);
   end

endmodule
`default_nettype wire

// File: rtl/bcd_clock_core.sv
`default_nettype none
// ============================================================================
// Module   : bcd_clock_core
// Purpose  : HH:MM:SS:CC BCD time-of-day counter with prescaler, run/stop,
//            12/24 h mode and edge-triggered validated field loads.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_clock_core
   import clock_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TICK_HZ   = 100,
   parameter int HOUR_MODE = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [7:0]  time_in,
   input  logic        set_hour,
   input  logic        set_minute,
   input  logic        set_second,
   input  logic        set_mil,
   output logic [31:0] time_bcd,
   output logic        tick,
   output logic        sec_pulse,
   output logic        day_wrap,
   output logic        pm,
   output logic        set_err
);

   localparam int         DIV          = CLK_HZ / TICK_HZ;
   localparam int         PW           = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] c_PRESC_LAST = PW'(DIV - 1);
   localparam bit         c_MODE12     = (HOUR_MODE == 12);
   localparam logic [7:0] c_HH_MAX     = c_MODE12 ? BCD_MAX_H12 : BCD_MAX_H24;
   localparam logic [7:0] c_HH_RST     = c_MODE12 ? 8'h12 : 8'h00;

   generate
      if (HOUR_MODE != 24 && HOUR_MODE != 12) begin : g_bad_hour_mode
         $error("bcd_clock_core: HOUR_MODE must be 12 or 24");
      end
      if (DIV < 2 || DIV * TICK_HZ != CLK_HZ) begin : g_bad_div
         $error("bcd_clock_core: CLK_HZ must be a multiple of TICK_HZ with DIV >= 2");
      end
   endgenerate

   logic [PW-1:0] r_presc;
   logic [3:0]    r_set_s1, r_set_s2;   // {hour, minute, second, mil}
   logic [1:0]    r_arm;
   logic [7:0]    r_hh;
   logic          r_pm;
   logic          r_tick, r_sec, r_wrap, r_err;

   logic [3:0]    w_rise, w_sel;
   logic          w_load, w_valid, w_load_ok, w_load_bad, w_adv;
   logic          w_cc_carry, w_ss_carry, w_mm_carry;
   logic [7:0]    w_cc, w_ss, w_mm, w_hh_next;
   logic          w_hh_wrap, w_pm_toggle;
   clock_time_t   w_time;

   // Strobe history; r_arm marks when both history stages hold real post-reset
   // samples, so a strobe already high at reset release is not seen as an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_set_s1 <= 4'b0;
         r_set_s2 <= 4'b0;
         r_arm    <= 2'b00;
      end else begin
         r_set_s1 <= {set_hour, set_minute, set_second, set_mil};
         r_set_s2 <= r_set_s1;
         r_arm    <= {r_arm[0], 1'b1};
      end
   end

   assign w_rise = r_set_s1 & ~r_set_s2 & {4{r_arm[1]}};

   // Priority select of one load and its validity check
   always_comb begin
      w_sel   = 4'b0000;
      w_valid = 1'b0;
      if (w_rise[3]) begin
         w_sel   = 4'b1000;
         w_valid = bcd_valid(time_in, c_HH_MAX) && (!c_MODE12 || time_in != 8'h00);
      end else if (w_rise[2]) begin
         w_sel   = 4'b0100;
         w_valid = bcd_valid(time_in, BCD_MAX_MS);
      end else if (w_rise[1]) begin
         w_sel   = 4'b0010;
         w_valid = bcd_valid(time_in, BCD_MAX_MS);
      end else if (w_rise[0]) begin
         w_sel   = 4'b0001;
         w_valid = bcd_valid(time_in, BCD_MAX_CC);
      end
   end

   assign w_load     = |w_rise;
   assign w_load_ok  = w_load && w_valid;
   assign w_load_bad = w_load && !w_valid;
   assign w_adv      = run && !w_load && (r_presc == c_PRESC_LAST);

   // Prescaler: cleared by a good load, frozen by a rejected load or run=0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_presc <= '0;
      else if (w_load_ok)
         r_presc <= '0;
      else if (run && !w_load)
         r_presc <= (r_presc == c_PRESC_LAST) ? '0 : r_presc + 1'b1;
   end

   bcd_mod_counter #(.MIN(8'h00), .MAX(BCD_MAX_CC)) u_cc (
      .clk(clk), .rst(rst), .inc(w_adv), .load(w_load_ok && w_sel[0]),
      .load_val(time_in), .value(w_cc), .carry(w_cc_carry)
   );

   bcd_mod_counter #(.MIN(8'h00), .MAX(BCD_MAX_MS)) u_ss (
      .clk(clk), .rst(rst), .inc(w_cc_carry), .load(w_load_ok && w_sel[1]),
      .load_val(time_in), .value(w_ss), .carry(w_ss_carry)
   );

   bcd_mod_counter #(.MIN(8'h00), .MAX(BCD_MAX_MS)) u_mm (
      .clk(clk), .rst(rst), .inc(w_ss_carry), .load(w_load_ok && w_sel[2]),
      .load_val(time_in), .value(w_mm), .carry(w_mm_carry)
   );

   // Hour sequence: 00..23 in 24 h mode, 12,01..11 with pm toggle in 12 h mode
   always_comb begin
      w_hh_next   = r_hh;
      w_hh_wrap   = 1'b0;
      w_pm_toggle = 1'b0;
      if (w_mm_carry) begin
         if (c_MODE12) begin
            if (r_hh == 8'h12) begin
               w_hh_next = 8'h01;
            end else if (r_hh == 8'h11) begin
               w_hh_next   = 8'h12;
               w_pm_toggle = 1'b1;
               w_hh_wrap   = r_pm;
            end else begin
               w_hh_next = bcd_inc(r_hh);
            end
         end else if (r_hh == BCD_MAX_H24) begin
            w_hh_next = 8'h00;
            w_hh_wrap = 1'b1;
         end else begin
            w_hh_next = bcd_inc(r_hh);
         end
      end
   end

   // Hour and pm registers; an hour load leaves pm alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hh <= c_HH_RST;
         r_pm <= 1'b0;
      end else begin
         if (w_load_ok && w_sel[3])
            r_hh <= time_in;
         else
            r_hh <= w_hh_next;
         if (w_pm_toggle)
            r_pm <= ~r_pm;
      end
   end

   // Status pulses, registered so no input reaches an output combinationally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick <= 1'b0;
         r_sec  <= 1'b0;
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_tick <= w_adv;
         r_sec  <= w_cc_carry;
         r_wrap <= w_hh_wrap;
         r_err  <= w_load_bad;
      end
   end

   assign w_time.hh = r_hh;
   assign w_time.mm = w_mm;
   assign w_time.ss = w_ss;
   assign w_time.cc = w_cc;

   assign time_bcd[HH_LSB +: 8] = w_time.hh;
   assign time_bcd[MM_LSB +: 8] = w_time.mm;
   assign time_bcd[SS_LSB +: 8] = w_time.ss;
   assign time_bcd[CC_LSB +: 8] = w_time.cc;

   assign tick      = r_tick;
   assign sec_pulse = r_sec;
   assign day_wrap  = r_wrap;
   assign pm        = r_pm;
   assign set_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_clock_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_clock_core
// Purpose  : Self-checking bench for bcd_clock_core, 24 h and 12 h instances
//            side by side against a time-in-hundredths reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_clock_core;

   localparam int DIV = 10;
   localparam int DAY = 8_640_000;   // hundredths per day

   logic        clk = 1'b0, rst = 1'b1, run = 1'b0;
   logic [7:0]  time_in = 8'h00;
   logic        set_hour = 1'b0, set_minute = 1'b0, set_second = 1'b0, set_mil = 1'b0;
   logic [31:0] time24, time12;
   logic        tick24, sec24, wrap24, pm24, err24;
   logic        tick12, sec12, wrap12, pm12, err12;

   bcd_clock_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MODE(24)) u_dut24 (
      .clk(clk), .rst(rst), .run(run), .time_in(time_in),
      .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second), .set_mil(set_mil),
      .time_bcd(time24), .tick(tick24), .sec_pulse(sec24), .day_wrap(wrap24),
      .pm(pm24), .set_err(err24)
   );

   bcd_clock_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MODE(12)) u_dut12 (
      .clk(clk), .rst(rst), .run(run), .time_in(time_in),
      .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second), .set_mil(set_mil),
      .time_bcd(time12), .tick(tick12), .sec_pulse(sec12), .day_wrap(wrap12),
      .pm(pm12), .set_err(err12)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // Reference model: time of day as hundredths since midnight per instance
   int         t [2];
   int         presc [2];
   bit         e_tick [2], e_sec [2], e_wrap [2], e_err [2];
   logic [3:0] h0, h1;
   int         since;

   function automatic logic [7:0] to_bcd(input int x);
      return 8'(((x / 10) * 16) + (x % 10));
   endfunction

   function automatic bit fld_ok(input int m, input int f, input logic [7:0] v);
      int hi, lo, n;
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      n  = hi * 10 + lo;
      if (hi > 9 || lo > 9) return 1'b0;
      case (f)
         3:       return (m == 1) ? (n >= 1 && n <= 12) : (n < 24);
         2, 1:    return n < 60;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [36:0] exp_vec(input int m);
      int h24, hd;
      logic [31:0] tv;
      h24 = t[m] / 360000;
      hd  = (m == 1) ? (((h24 % 12) == 0) ? 12 : (h24 % 12)) : h24;
      tv  = {to_bcd(hd), to_bcd((t[m] / 6000) % 60), to_bcd((t[m] / 100) % 60), to_bcd(t[m] % 100)};
      return {tv, (m == 1) && (h24 >= 12), e_tick[m], e_sec[m], e_wrap[m], e_err[m]};
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         t[m] = 0; presc[m] = 0;
         e_tick[m] = 1'b0; e_sec[m] = 1'b0; e_wrap[m] = 1'b0; e_err[m] = 1'b0;
      end
      h0 = 4'b0; h1 = 4'b0; since = 0;
   endtask

   task automatic model_edge();
      logic [3:0] cur, rise;
      int f, n, h, mi, s, c;
      cur = {set_hour, set_minute, set_second, set_mil};
      if (rst) begin
         model_reset();
         return;
      end
      rise = (since >= 2) ? (h1 & ~h0) : 4'b0;
      f = rise[3] ? 3 : rise[2] ? 2 : rise[1] ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
         e_tick[m] = 1'b0; e_sec[m] = 1'b0; e_wrap[m] = 1'b0; e_err[m] = 1'b0;
         if (rise != 4'b0) begin
            if (fld_ok(m, f, time_in)) begin
               n  = int'(time_in[7:4]) * 10 + int'(time_in[3:0]);
               h  = t[m] / 360000;
               mi = (t[m] / 6000) % 60;
               s  = (t[m] / 100) % 60;
               c  = t[m] % 100;
               case (f)
                  3:       h  = (m == 1) ? ((n % 12) + ((h >= 12) ? 12 : 0)) : n;
                  2:       mi = n;
                  1:       s  = n;
                  default: c  = n;
               endcase
               t[m] = h * 360000 + mi * 6000 + s * 100 + c;
               presc[m] = 0;
            end else begin
               e_err[m] = 1'b1;
            end
         end else if (run) begin
            if (presc[m] == DIV - 1) begin
               presc[m]  = 0;
               t[m]      = (t[m] + 1) % DAY;
               e_tick[m] = 1'b1;
               e_sec[m]  = (t[m] % 100) == 0;
               e_wrap[m] = (t[m] == 0);
            end else begin
               presc[m]++;
            end
         end
      end
      h0 = h1;
      h1 = cur;
      if (since < 2) since++;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("dut24_outputs", 64'({time24, pm24, tick24, sec24, wrap24, err24}), 64'(exp_vec(0)));
      chk("dut12_outputs", 64'({time12, pm12, tick12, sec12, wrap12, err12}), 64'(exp_vec(1)));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      step();
      step();
      #2 rst = 1'b0;
      step();
      step();
   endtask

   task automatic load(input logic [3:0] sel, input logic [7:0] val);
      time_in = val;
      {set_hour, set_minute, set_second, set_mil} = sel;
      step();
      step();
      {set_hour, set_minute, set_second, set_mil} = 4'b0;
      step();
      step();
   endtask

   // Step until the selected instance ticks or the bound expires
   task automatic wait_tick(input int m, input int bound, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (n < bound && ((m == 0) ? !tick24 : !tick12));
   endtask

   typedef struct {
      logic [3:0]  sel;
      logic [7:0]  val;
      logic [31:0] t24;
      logic        e24;
      logic [31:0] t12;
      logic        e12;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int n;
      tbl[0]  = '{4'b1000, 8'h05, 32'h05000000, 1'b0, 32'h05000000, 1'b0};
      tbl[1]  = '{4'b0100, 8'h60, 32'h05000000, 1'b1, 32'h05000000, 1'b1};
      tbl[2]  = '{4'b1000, 8'h1A, 32'h05000000, 1'b1, 32'h05000000, 1'b1};
      tbl[3]  = '{4'b1000, 8'h00, 32'h00000000, 1'b0, 32'h05000000, 1'b1};
      tbl[4]  = '{4'b0100, 8'h59, 32'h00590000, 1'b0, 32'h05590000, 1'b0};
      tbl[5]  = '{4'b0010, 8'h07, 32'h00590700, 1'b0, 32'h05590700, 1'b0};
      tbl[6]  = '{4'b0001, 8'h9A, 32'h00590700, 1'b1, 32'h05590700, 1'b1};
      tbl[7]  = '{4'b0001, 8'h99, 32'h00590799, 1'b0, 32'h05590799, 1'b0};
      tbl[8]  = '{4'b1000, 8'h13, 32'h13590799, 1'b0, 32'h05590799, 1'b1};
      tbl[9]  = '{4'b1000, 8'h12, 32'h12590799, 1'b0, 32'h12590799, 1'b0};
      tbl[10] = '{4'b1010, 8'h05, 32'h05590799, 1'b0, 32'h05590799, 1'b0};
      tbl[11] = '{4'b0010, 8'h5F, 32'h05590799, 1'b1, 32'h05590799, 1'b1};

      // Reset values, then first tick and first second with run=1
      model_reset();
      run = 1'b1;
      step();
      step();
      chk("reset_time24", 64'(time24), 64'h00000000);
      chk("reset_time12", 64'(time12), 64'h12000000);
      chk("reset_flags24", 64'({tick24, sec24, wrap24, err24, pm24}), 64'h0);
      #2 rst = 1'b0;
      wait_tick(0, 20, n);
      chk("first_tick_latency", 64'(n), 64'd10);
      chk("first_tick_time", 64'(time24), 64'h00000001);
      for (int i = 0; i < 990; i++) step();
      chk("sec_pulse_100_ticks", 64'(sec24), 64'h1);
      chk("time_after_100_ticks", 64'(time24), 64'h00000100);

      // Table of single loads with run=0, cumulative from reset
      run = 1'b0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         time_in = tbl[i].val;
         {set_hour, set_minute, set_second, set_mil} = tbl[i].sel;
         step();
         step();
         chk($sformatf("tbl%0d_time24", i), 64'(time24), 64'(tbl[i].t24));
         chk($sformatf("tbl%0d_err24", i), 64'(err24), 64'(tbl[i].e24));
         chk($sformatf("tbl%0d_time12", i), 64'(time12), 64'(tbl[i].t12));
         chk($sformatf("tbl%0d_err12", i), 64'(err12), 64'(tbl[i].e12));
         {set_hour, set_minute, set_second, set_mil} = 4'b0;
         step();
         step();
      end

      // 24 h day wrap from 23:59:59.99
      load(4'b1000, 8'h23);
      load(4'b0100, 8'h59);
      load(4'b0010, 8'h59);
      load(4'b0001, 8'h99);
      run = 1'b1;
      wait_tick(0, 20, n);
      chk("wrap24_tick", 64'(tick24), 64'h1);
      chk("wrap24_time", 64'(time24), 64'h00000000);
      chk("wrap24_day_wrap", 64'(wrap24), 64'h1);
      step();
      chk("wrap24_day_wrap_1cyc", 64'(wrap24), 64'h0);

      // 12 h: 11:59:59.99 am -> 12 pm, then 11:59:59.99 pm -> 12 am with wrap
      run = 1'b0;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         run = 1'b0;
         load(4'b1000, 8'h11);
         load(4'b0100, 8'h59);
         load(4'b0010, 8'h59);
         load(4'b0001, 8'h99);
         run = 1'b1;
         wait_tick(1, 20, n);
         chk($sformatf("h12_pass%0d_time", k), 64'(time12), 64'h12000000);
         chk($sformatf("h12_pass%0d_pm", k), 64'(pm12), (k == 0) ? 64'h1 : 64'h0);
         chk($sformatf("h12_pass%0d_wrap", k), 64'(wrap12), (k == 0) ? 64'h0 : 64'h1);
      end

      // Held strobe loads once; a later change of time_in is ignored
      run = 1'b0;
      time_in = 8'h05;
      set_hour = 1'b1;
      for (int i = 0; i < 3; i++) step();
      time_in = 8'h07;
      for (int i = 0; i < 17; i++) step();
      chk("held_strobe_hours", 64'(time24[31:24]), 64'h05);
      set_hour = 1'b0;
      step();
      step();

      // run=0 mid-count freezes time; resume finishes the remaining count
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 14; i++) step();
      run = 1'b0;
      n = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (tick24) n++;
      end
      chk("pause_no_tick", 64'(n), 64'd0);
      chk("pause_frozen", 64'(time24), 64'h00000001);
      run = 1'b1;
      begin
         int rem;
         rem = DIV - presc[0];
         wait_tick(0, 20, n);
         chk("resume_latency", 64'(n), 64'(rem));
      end

      // Asynchronous reset mid-count, then release with a strobe held high
      for (int i = 0; i < 3; i++) step();
      #3 rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      chk("async_rst_time24", 64'(time24), 64'h00000000);
      chk("async_rst_time12", 64'(time12), 64'h12000000);
      time_in = 8'h07;
      set_hour = 1'b1;
      step();
      step();
      #2 rst = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("rst_release_no_load", 64'(time24[31:24]), 64'h00);
      set_hour = 1'b0;
      step();

      // Randomised run, data and strobes
      for (int i = 0; i < 1500; i++) begin
         run = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0)
            time_in = 8'($urandom);
         else
            time_in = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
         if ($urandom_range(0, 11) == 0) set_hour   = ~set_hour;
         if ($urandom_range(0, 11) == 0) set_minute = ~set_minute;
         if ($urandom_range(0, 11) == 0) set_second = ~set_second;
         if ($urandom_range(0, 11) == 0) set_mil    = ~set_mil;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
